// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serialising three clients' read/write requests onto one memory port.
// Memory-side outputs are registered; read data lands in the owner's one-entry response slot.
module mem_port_arbiter #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req_valid,
  output logic [2:0]            req_ready,
  input  logic [2:0]            req_we,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*WIDTH-1:0]    req_wdata,
  output logic [2:0]            rsp_valid,
  input  logic [2:0]            rsp_ready,
  output logic [3*WIDTH-1:0]    rsp_data,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata
);

  logic [1:0]        rr_q, rr_d;
  logic [2:0]        inflight_q, inflight_d;
  logic [2:0]        rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_data_q [3];
  logic [WIDTH-1:0]  rsp_data_d [3];
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;

  logic [2:0]        eligible;
  logic [1:0]        cand [3];
  logic [ADDR_W-1:0] addr_arr [3];
  logic [WIDTH-1:0]  wdata_arr [3];
  logic              hs;
  logic [1:0]        gid;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_client
      logic [2:0] rr_sum;
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*WIDTH +: WIDTH];
      // A full or in-flight slot blocks reads only; writes never need a slot.
      assign eligible[gi]  = req_valid[gi] &
                             (req_we[gi] | (~inflight_q[gi] & (~rsp_valid_q[gi] | rsp_ready[gi])));
      assign rr_sum        = {1'b0, rr_q} + 3'(gi);
      assign cand[gi]      = (rr_sum >= 3'd3) ? 2'(rr_sum - 3'd3) : rr_sum[1:0];
      assign rsp_data[gi*WIDTH +: WIDTH] = rsp_data_q[gi];
    end
  endgenerate

  always_comb begin
    hs  = 1'b0;
    gid = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (!hs && eligible[cand[k]]) begin
        hs  = 1'b1;
        gid = cand[k];
      end
    end
  end

  always_comb begin
    req_ready = 3'b000;
    if (hs && rst) req_ready[gid] = 1'b1;
  end

  always_comb begin
    rr_d        = rr_q;
    inflight_d  = 3'b000;
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_data_d  = rsp_data_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    // The issue cycle of a read is exactly the cycle its inflight bit is set.
    for (int i = 0; i < 3; i++) begin
      if (inflight_q[i]) begin
        rsp_valid_d[i] = 1'b1;
        rsp_data_d[i]  = mem_rdata;
      end
    end
    if (hs) begin
      rr_d        = (gid == 2'd2) ? 2'd0 : gid + 2'd1;
      mem_we_d    = req_we[gid];
      mem_addr_d  = addr_arr[gid];
      mem_wdata_d = wdata_arr[gid];
      if (!req_we[gid]) inflight_d[gid] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q        <= 2'd0;
      inflight_q  <= 3'b000;
      rsp_valid_q <= 3'b000;
      for (int i = 0; i < 3; i++) rsp_data_q[i] <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      rr_q        <= rr_d;
      inflight_q  <= inflight_d;
      rsp_valid_q <= rsp_valid_d;
      for (int i = 0; i < 3; i++) rsp_data_q[i] <= rsp_data_d[i];
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, every cycle
// compared against a transaction-level model of grants, slots and memory contents.
module tb_mem_port_arbiter;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = '0, req_we = '0, rsp_ready = '0;
  logic [47:0] req_addr = '0;
  logic [23:0] req_wdata = '0;
  logic [2:0]  req_ready, rsp_valid;
  logic [23:0] rsp_data;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory attached to the port: combinational read, write at the end of the issue cycle.
  logic [7:0] mem [65536];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  ref_mem [65536];
  int          m_rr;
  bit          m_sv [3];
  logic [7:0]  m_sd [3];
  int          m_pend;
  logic [7:0]  m_pend_data;
  logic        m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_rr = 0; m_pend = -1; m_pend_data = '0;
    m_we = 1'b0; m_addr = '0; m_wd = '0;
    for (int i = 0; i < 3; i++) begin m_sv[i] = 1'b0; m_sd[i] = '0; end
  endfunction

  function automatic int exp_grant();
    for (int k = 0; k < 3; k++) begin
      int c;
      bit free;
      c = (m_rr + k) % 3;
      free = (m_pend != c) && (!m_sv[c] || rsp_ready[c]);
      if (req_valid[c] && (req_we[c] || free)) return c;
    end
    return -1;
  endfunction

  task automatic check_outputs(input int g);
    logic [2:0] erdy;
    logic [2:0] esv;
    erdy = '0;
    if (rst && g >= 0) erdy[g] = 1'b1;
    esv = {m_sv[2], m_sv[1], m_sv[0]};
    chk("req_ready", {29'd0, req_ready}, {29'd0, erdy});
    chk("rsp_valid", {29'd0, rsp_valid}, {29'd0, esv});
    chk("rsp_data", {8'd0, rsp_data}, {8'd0, m_sd[2], m_sd[1], m_sd[0]});
    chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
    chk("mem_addr", {16'd0, mem_addr}, {16'd0, m_addr});
    chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, m_wd});
  endtask

  function automatic void model_edge(input int g);
    for (int i = 0; i < 3; i++) if (m_sv[i] && rsp_ready[i]) m_sv[i] = 1'b0;
    if (m_pend >= 0) begin
      m_sv[m_pend] = 1'b1;
      m_sd[m_pend] = m_pend_data;
      m_pend = -1;
    end
    if (g >= 0) begin
      m_we   = req_we[g];
      m_addr = req_addr[g*16 +: 16];
      m_wd   = req_wdata[g*8 +: 8];
      // Requests hit memory in grant order, so a read sees every earlier-granted write.
      if (req_we[g]) ref_mem[m_addr] = m_wd;
      else begin m_pend = g; m_pend_data = ref_mem[m_addr]; end
      m_rr = (g + 1) % 3;
    end else begin
      m_we = 1'b0;
    end
  endfunction

  // One clock cycle: starts and ends just after a falling edge.
  task automatic cyc(input logic [2:0] v, input logic [2:0] we, input logic [2:0] rr,
                     input logic [47:0] a, input logic [23:0] wd, output logic [2:0] rdy);
    int g;
    req_valid = v; req_we = we; rsp_ready = rr; req_addr = a; req_wdata = wd;
    #1;
    g = exp_grant();
    check_outputs(g);
    rdy = req_ready;
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge(g);
    @(negedge clk);
  endtask

  function automatic logic [47:0] A(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2);
    return {a2, a1, a0};
  endfunction

  function automatic logic [23:0] W(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    return {d2, d1, d0};
  endfunction

  logic [2:0] r;
  logic [7:0] d;

  initial begin
    model_reset();
    #1 rst = 1'b0;
    @(negedge clk);

    // Reset held with every client requesting
    cyc(3'b111, 3'b111, 3'b111, A(16'h1, 16'h2, 16'h3), W(8'h11, 8'h22, 8'h33), r);
    chk("reset_ready", {29'd0, r}, 32'd0);
    cyc(3'b111, 3'b111, 3'b111, A(16'h1, 16'h2, 16'h3), W(8'h11, 8'h22, 8'h33), r);
    rst = 1'b1;

    // First grants after release rotate 0,1,2
    cyc(3'b111, 3'b111, 3'b111, A(16'h1, 16'h2, 16'h3), W(8'h11, 8'h22, 8'h33), r);
    chk("first_grant", {29'd0, r}, 32'd1);
    cyc(3'b111, 3'b111, 3'b111, A(16'h1, 16'h2, 16'h3), W(8'h11, 8'h22, 8'h33), r);
    chk("rot_grant1", {29'd0, r}, 32'd2);
    cyc(3'b111, 3'b111, 3'b111, A(16'h1, 16'h2, 16'h3), W(8'h11, 8'h22, 8'h33), r);
    chk("rot_grant2", {29'd0, r}, 32'd4);

    // Preload addresses 0..31 through client 0; 0x10 holds 0xA5
    for (int i = 0; i < 32; i++) begin
      d = (i == 16) ? 8'hA5 : 8'($urandom);
      cyc(3'b001, 3'b001, 3'b111, A(16'(i), 16'h0, 16'h0), W(d, 8'h0, 8'h0), r);
    end

    // All three clients reading continuously
    for (int i = 0; i < 8; i++) begin
      cyc(3'b111, 3'b000, 3'b111, A(16'h1, 16'h2, 16'h3), '0, r);
      chk("rot_onehot", $countones(r), (r == 3'b000) ? 32'd0 : 32'd1);
    end
    cyc(3'b000, 3'b000, 3'b111, '0, '0, r);

    // Single read by client 1
    cyc(3'b010, 3'b000, 3'b111, A(16'h0, 16'h0010, 16'h0), '0, r);
    chk("single_grant", {29'd0, r}, 32'd2);
    cyc(3'b000, 3'b000, 3'b000, '0, '0, r);
    chk("single_valid", {31'd0, rsp_valid[1]}, 32'd1);
    chk("single_data", {24'd0, rsp_data[15:8]}, 32'hA5);

    // Backpressure on client 2
    cyc(3'b100, 3'b000, 3'b100, A(16'h0, 16'h0, 16'h5), '0, r);
    chk("bp_first", {29'd0, r}, 32'd4);
    cyc(3'b000, 3'b000, 3'b000, '0, '0, r);
    cyc(3'b111, 3'b000, 3'b011, A(16'h5, 16'h6, 16'h7), '0, r);
    chk("bp_blocked", {29'd0, r}, 32'd1);
    cyc(3'b100, 3'b100, 3'b011, A(16'h0, 16'h0, 16'h7), W(8'h0, 8'h0, 8'h99), r);
    chk("bp_write_ok", {29'd0, r}, 32'd4);
    cyc(3'b100, 3'b000, 3'b100, A(16'h0, 16'h0, 16'h7), '0, r);
    chk("bp_release", {29'd0, r}, 32'd4);
    cyc(3'b000, 3'b000, 3'b111, '0, '0, r);

    // Write-then-read hazard on 0x0042
    cyc(3'b001, 3'b001, 3'b111, A(16'h0042, 16'h0, 16'h0), W(8'h3C, 8'h0, 8'h0), r);
    chk("haz_write", {29'd0, r}, 32'd1);
    cyc(3'b010, 3'b000, 3'b111, A(16'h0, 16'h0042, 16'h0), '0, r);
    chk("haz_read", {29'd0, r}, 32'd2);
    cyc(3'b000, 3'b000, 3'b000, '0, '0, r);
    chk("haz_valid", {31'd0, rsp_valid[1]}, 32'd1);
    chk("haz_data", {24'd0, rsp_data[15:8]}, 32'h3C);
    cyc(3'b000, 3'b000, 3'b111, '0, '0, r);

    // Reset while a read is in flight
    cyc(3'b001, 3'b000, 3'b111, A(16'h0042, 16'h0, 16'h0), '0, r);
    rst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_valid", {29'd0, rsp_valid}, 32'd0);
    chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
    chk("mid_rst_addr", {16'd0, mem_addr}, 32'd0);
    @(negedge clk);
    cyc(3'b000, 3'b000, 3'b111, '0, '0, r);
    rst = 1'b1;
    cyc(3'b000, 3'b000, 3'b000, '0, '0, r);
    cyc(3'b000, 3'b000, 3'b000, '0, '0, r);
    chk("no_stale", {29'd0, rsp_valid}, 32'd0);
    cyc(3'b100, 3'b000, 3'b111, A(16'h0, 16'h0, 16'h0042), '0, r);
    cyc(3'b000, 3'b000, 3'b000, '0, '0, r);
    chk("kept_valid", {31'd0, rsp_valid[2]}, 32'd1);
    chk("kept_data", {24'd0, rsp_data[23:16]}, 32'h3C);

    // Random traffic over the preloaded address window
    for (int i = 0; i < 400; i++) begin
      cyc(3'($urandom), 3'($urandom), 3'($urandom),
          A(16'($urandom_range(0, 31)), 16'($urandom_range(0, 31)), 16'($urandom_range(0, 31))),
          24'($urandom), r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
